// File: rtl/ca3_serial_subtractor.sv
// Bit-serial N-bit subtractor, LSB first, one bit per clock through an IDLE/RUN/DONE FSM.
// Optional signed overflow flag (port ovf) is built only when SUB_OVERFLOW_EN is defined.
module ca3_serial_subtractor #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         bout
`ifdef SUB_OVERFLOW_EN
    ,
    output logic         ovf
`endif
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic [N-1:0]    r_res;
    logic [N-1:0]    r_diff;
    logic [CW-1:0]   r_cnt;
    logic            r_br;
    logic            r_bout;
    logic            w_d;
    logic            w_brNext;
    logic            w_lastBit;
    logic [N-1:0]    w_result;
`ifdef SUB_OVERFLOW_EN
    logic            r_aMsb;
    logic            r_bMsb;
    logic            r_ovf;
`endif

    assign w_d       = r_a[0] ^ r_b[0] ^ r_br;
    assign w_brNext  = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    assign w_lastBit = (r_cnt == CW'(N - 1));
    assign w_result  = {w_d, r_res[N-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_lastBit) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                done        = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Visible results only change on the final RUN cycle, so they hold through DONE and IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_res  <= '0;
            r_diff <= '0;
            r_cnt  <= '0;
            r_br   <= 1'b0;
            r_bout <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            r_aMsb <= 1'b0;
            r_bMsb <= 1'b0;
            r_ovf  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_res <= '0;
                        r_cnt <= '0;
                        r_br  <= 1'b0;
`ifdef SUB_OVERFLOW_EN
                        r_aMsb <= a[N-1];
                        r_bMsb <= b[N-1];
`endif
                    end
                end
                RUN: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_res <= w_result;
                    r_br  <= w_brNext;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_lastBit) begin
                        r_diff <= w_result;
                        r_bout <= w_brNext;
`ifdef SUB_OVERFLOW_EN
                        r_ovf  <= (r_aMsb != r_bMsb) && (w_result[N-1] != r_aMsb);
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign diff = r_diff;
    assign bout = r_bout;
`ifdef SUB_OVERFLOW_EN
    assign ovf  = r_ovf;
`endif

endmodule

// File: doc/ca3_serial_subtractor.md
CA3_SERIAL_SUBTRACTOR -- requirements
Module: ca3_serial_subtractor

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the operand and result width in bits (N >= 2).
REQ-002 `clk` SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-003 `rst_n` SHALL be an input, 1 bit wide: the reset, asynchronous and active-low.
REQ-004 `start` SHALL be an input, 1 bit wide: request to begin a subtraction.
REQ-005 `a` SHALL be an input, N bits wide: the minuend, sampled when start is accepted.
REQ-006 `b` SHALL be an input, N bits wide: the subtrahend, sampled when start is accepted.
REQ-007 `busy` SHALL be an output, 1 bit wide: high while an operation is in progress (RUN state).
REQ-008 `done` SHALL be an output, 1 bit wide: a one-cycle pulse marking that the result is valid.
REQ-009 `diff` SHALL be an output, N bits wide: the result a - b modulo 2^N.
REQ-010 `bout` SHALL be an output, 1 bit wide: the borrow out; 1 iff a < b unsigned.
REQ-011 `ovf` SHALL be an output, 1 bit wide, present only when SUB_OVERFLOW_EN is defined: the signed overflow flag.

Function
REQ-012 The block SHALL be a three-state FSM with states IDLE, RUN and DONE.
REQ-013 In IDLE, start=1 at a rising edge SHALL:
- load a and b into shift registers;
- clear the borrow register and the bit counter;
- move the FSM to RUN.
REQ-014 start SHALL be accepted only in IDLE, and SHALL be ignored in RUN and DONE.
REQ-015 In RUN, each cycle SHALL process one bit, LSB first:
- d = a0 ^ b0 ^ br;
- br_next = (~a0 & b0) | (~(a0 ^ b0) & br);
- d is shifted into the MSB of the result register;
- both operand registers shift right by one.
REQ-016 RUN SHALL last exactly N cycles; after the Nth bit the FSM SHALL go to DONE.
REQ-017 In DONE, done SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE on the next edge.
REQ-018 Latency: with start accepted at edge k, done SHALL be high in the cycle following edge k+N, so results are valid N+1 edges after acceptance.
REQ-019 busy SHALL equal 1 exactly while the FSM is in RUN.
REQ-020 diff and bout SHALL be driven from registers that are updated only at the end of RUN; they SHALL hold their values through DONE and IDLE until the next completed operation.
REQ-021 Changes on a or b after acceptance SHALL NOT affect the operation in progress.
REQ-022 Boundary cases:
- a = b SHALL give diff = 0, bout = 0;
- a = 0, b = 2^N - 1 SHALL give diff = 1, bout = 1.

Reset
REQ-023 While rst_n = 0, regardless of clk:
- the FSM SHALL be in IDLE;
- busy, done, diff, bout and ovf (if present) SHALL be 0;
- the counter, borrow and operand registers SHALL be 0.
REQ-024 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the first start after rst_n rises SHALL be accepted normally.

Configuration
REQ-025 With macro SUB_OVERFLOW_EN defined:
- port ovf SHALL exist;
- at the end of RUN, ovf SHALL be registered as (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]) on the captured operands;
- ovf SHALL hold alongside diff.
REQ-026 Without SUB_OVERFLOW_EN, port ovf and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-027 N=4, a=1, b=15, start pulse -> done after 5 edges, diff=2, bout=1, busy high for 4 cycles.
REQ-028 N=4, a=9, b=3 -> diff=6, bout=0; a=5, b=5 -> diff=0, bout=0.
REQ-029 N=4, start held high for the whole operation with a=7, b=2 -> one done pulse, diff=5; the second start is accepted only after the return to IDLE, so the next done comes 5 edges after the IDLE cycle.
REQ-030 N=4, a=12, b=4, rst_n driven low at cycle 2 of RUN -> immediately all outputs 0 and no done; after release, a=12, b=4 -> diff=8, bout=0.
REQ-031 SUB_OVERFLOW_EN, N=4, a=8 (-8), b=1 -> diff=7, bout=0, ovf=1; a=1, b=15 -> diff=2, ovf=0.
REQ-032 Change a and b every cycle during RUN after a=10, b=3 was accepted -> diff=7, unaffected.
